// File: rtl/led_panel_cmd_ctrl.sv
// led_panel_cmd_ctrl
// Decodes the UART byte stream into pixel, clear-screen and colour commands.
// Frame-buffer writes are held in a small FIFO and issued one per cycle, only
// while the panel scanner is not reading the buffer, so rows never tear.

module led_panel_cmd_ctrl #(
    parameter int           QDEPTH    = 4,
    parameter logic [2:0]   RESET_RGB = 3'b101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    input  logic        scan_active,
    output logic        fb_we,
    output logic        fb_set,
    output logic [3:0]  fb_col,
    output logic [2:0]  fb_row,
    output logic        fb_clr,
    output logic [2:0]  rgb,
    output logic        busy,
    output logic        err,
    output logic        ovf
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_CMD,
        S_ADDR
    } state_t;

    typedef enum logic [1:0] {
        OP_SET = 2'd0,
        OP_CLR = 2'd1,
        OP_CLS = 2'd2
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] col;
        logic [2:0] row;
    } entry_t;

    state_t         state, state_nx;
    op_t            pend_op, pend_op_nx;
    logic           push_req;
    entry_t         push_entry;
    logic           err_nx;
    logic           rgb_load;

    entry_t         mem [QDEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           pop;
    logic           push_ok;
    entry_t         rd_entry;

    // Byte decoder: next state, pending op, queue push request and error flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_nx   = state;
        pend_op_nx = pend_op;
        push_req   = 1'b0;
        push_entry = '{op: OP_SET, col: 4'd0, row: 3'd0};
        err_nx     = 1'b0;
        rgb_load   = 1'b0;
        if (rx_dv) begin
            case (state)
                S_CMD: begin
                    case (rx_data[7:4])
                        4'h0: rgb_load = 1'b1;
                        4'h1: begin
                            state_nx   = S_ADDR;
                            pend_op_nx = OP_SET;
                        end
                        4'h2: begin
                            state_nx   = S_ADDR;
                            pend_op_nx = OP_CLR;
                        end
                        4'h3: begin
                            push_req   = 1'b1;
                            push_entry = '{op: OP_CLS, col: 4'd0, row: 3'd0};
                        end
                        4'hF: ;  // no-op filler byte
                        default: err_nx = 1'b1;
                    endcase
                end
                S_ADDR: begin
                    state_nx = S_CMD;
                    if (rx_data == 8'hF5) begin
                        // abort: drop the pending op silently
                    end else if (rx_data[3]) begin
                        err_nx = 1'b1;
                    end else begin
                        push_req   = 1'b1;
                        push_entry = '{op: pend_op, col: rx_data[7:4], row: rx_data[2:0]};
                    end
                end
                default: state_nx = S_CMD;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full queue is
    // still accepted when an entry is leaving.
    assign pop      = (count != '0) && !scan_active;
    assign push_ok  = push_req && ((count != CW'(QDEPTH)) || pop);
    assign rd_entry = mem[rd_ptr];
    assign busy     = (state == S_ADDR) || (count != '0);

    // Decoder state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= S_CMD;
            pend_op <= OP_SET;
        end else begin
            state   <= state_nx;
            pend_op <= pend_op_nx;
        end
    end

    // Queue storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count define validity, so stale contents are never read.
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered outputs: colour, write/clear strobes, error and overflow pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb    <= RESET_RGB;
            fb_we  <= 1'b0;
            fb_set <= 1'b0;
            fb_col <= 4'd0;
            fb_row <= 3'd0;
            fb_clr <= 1'b0;
            err    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            fb_we  <= 1'b0;
            fb_clr <= 1'b0;
            err    <= err_nx;
            ovf    <= push_req && !push_ok;
            if (rgb_load) rgb <= rx_data[2:0];
            if (pop) begin
                if (rd_entry.op == OP_CLS) begin
                    fb_clr <= 1'b1;
                end else begin
                    fb_we  <= 1'b1;
                    fb_set <= (rd_entry.op == OP_SET);
                    fb_col <= rd_entry.col;
                    fb_row <= rd_entry.row;
                end
            end
        end
    end

endmodule
